// File: rtl/gd_pkg.sv
// Shared definitions for the gradient-descent datapath stages:
// Q24.8 constants, the FSM state type and the 64->32 saturating clamp.
package gd_pkg;

   localparam int DATA_W     = 32;
   localparam int FRACT_BITS = 8;

   localparam logic signed [DATA_W-1:0] Q_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [DATA_W-1:0] Q_MIN = 32'sh8000_0000;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      DRAIN  = 2'd1,
      DONE   = 2'd2
   } gd_state_t;

   typedef struct packed {
      logic                     ovf;
      logic signed [DATA_W-1:0] val;
   } sat_t;

   // Clamp a signed 64-bit value into Q24.8 range and report whether it clipped.
   function automatic sat_t sat32(input logic signed [63:0] v);
      sat_t r;
      r.ovf = 1'b0;
      r.val = v[DATA_W-1:0];
      if (v > 64'sh0000_0000_7FFF_FFFF) begin
         r.ovf = 1'b1;
         r.val = Q_MAX;
      end else if (v < 64'shFFFF_FFFF_8000_0000) begin
         r.ovf = 1'b1;
         r.val = Q_MIN;
      end
      return r;
   endfunction

endpackage

// File: rtl/grad_param_update_if.sv
// Gradient beat stream into the parameter-update stage (valid/ready handshake).
interface grad_param_update_if;

   logic                         grad_valid;
   logic                         grad_ready;
   logic [gd_pkg::DATA_W-1:0]    grad_data;
   logic                         grad_last;

   modport master (output grad_valid, output grad_data, output grad_last, input grad_ready);
   modport slave  (input grad_valid, input grad_data, input grad_last, output grad_ready);

endinterface

// File: rtl/fixed_64_mult.sv
// Signed 32x32 fixed-point multiply; full 64-bit product shifted right by SHIFT.
module fixed_64_mult #(
   parameter int SHIFT = 8
) (
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic signed [63:0] y
);

   logic signed [63:0] full;

   // Low 64 bits of the sign-extended product equal the exact signed product.
   assign full = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign y    = full >>> SHIFT;

endmodule

// File: rtl/grad_param_update.sv
// Parameter-update stage: param[i] -= sat(grad[i] * lr) per vector, with
// sticky saturation/sequence flags and a per-vector convergence result.
module grad_param_update #(
   parameter int                 DIM         = 4,
   parameter int                 FRACT_BITS  = 8,
   parameter logic signed [31:0] CONV_THRESH = 32'sd4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              lr_in,
   input  logic                     init_en,
   input  logic [$clog2(DIM)-1:0]   init_idx,
   input  logic [31:0]              init_data,
   grad_param_update_if.slave       grad,
   output logic [DIM*32-1:0]        param_out,
   output logic                     upd_valid,
   output logic                     converged,
   output logic                     sat_flag,
   output logic                     seq_err
);

   import gd_pkg::*;

   localparam int               IDX_W    = $clog2(DIM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

   gd_state_t          state;
   gd_state_t          state_nxt;
   logic               drain_cnt;
   logic [IDX_W-1:0]   idx;
   logic               xfer;
   logic               last_beat;
   logic               init_ok;
   logic               s1_valid;
   logic signed [31:0] s1_step;
   logic [IDX_W-1:0]   s1_idx;
   logic signed [31:0] param [DIM];
   logic               conv_acc;
   logic signed [63:0] prod;
   sat_t               prod_sat;
   sat_t               diff_sat;
   logic signed [32:0] diff;
   logic [32:0]        step_abs;

   fixed_64_mult #(.SHIFT(FRACT_BITS)) u_mult (
      .a (grad.grad_data),
      .b (lr_in),
      .y (prod)
   );

   assign xfer      = grad.grad_valid & grad.grad_ready;
   assign last_beat = (idx == LAST_IDX);
   assign init_ok   = init_en && (state == ACCEPT) && (idx == '0) && !s1_valid && !xfer;

   assign prod_sat  = sat32(prod);
   assign diff      = {param[s1_idx][31], param[s1_idx]} - {s1_step[31], s1_step};
   assign diff_sat  = sat32({{31{diff[32]}}, diff});
   // 33-bit magnitude so that the most negative step reads as +2^31.
   assign step_abs  = s1_step[31] ? (33'd0 - {1'b1, s1_step}) : {1'b0, s1_step};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCEPT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCEPT:  if (xfer && last_beat) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt) state_nxt = DONE;
         DONE:    state_nxt = ACCEPT;
         default: state_nxt = ACCEPT;
      endcase
   end

   always_comb begin
      grad.grad_ready = (state == ACCEPT);
      upd_valid       = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt <= 1'b0;
         idx       <= '0;
         s1_valid  <= 1'b0;
         s1_step   <= '0;
         s1_idx    <= '0;
         conv_acc  <= 1'b1;
         converged <= 1'b0;
         sat_flag  <= 1'b0;
         seq_err   <= 1'b0;
         for (int i = 0; i < DIM; i++) param[i] <= '0;
      end else begin
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         s1_valid  <= xfer;
         if (xfer) begin
            s1_step <= prod_sat.val;
            s1_idx  <= idx;
            idx     <= last_beat ? '0 : idx + IDX_W'(1);
            if (prod_sat.ovf) sat_flag <= 1'b1;
            if (grad.grad_last != last_beat) seq_err <= 1'b1;
         end
         // Stage-2 writes and init writes never collide: init needs an empty pipe.
         if (s1_valid) begin
            param[s1_idx] <= diff_sat.val;
            if (diff_sat.ovf) sat_flag <= 1'b1;
            if (step_abs >= {1'b0, CONV_THRESH}) conv_acc <= 1'b0;
         end else if (init_ok) begin
            param[init_idx] <= init_data;
         end
         if (state == DRAIN && drain_cnt) converged <= conv_acc;
         if (state == DONE) conv_acc <= 1'b1;
      end
   end

   always_comb begin
      param_out = '0;
      for (int i = 0; i < DIM; i++) param_out[32*i +: 32] = param[i];
   end

endmodule

// File: tb/tb_grad_param_update.sv
// Directed bench for grad_param_update (DIM=4): hand-computed Q24.8 results
// for update, convergence, saturation, sequencing, init gating and reset.
module tb_grad_param_update;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  lr_in;
   logic         init_en;
   logic [1:0]   init_idx;
   logic [31:0]  init_data;
   logic [127:0] param_out;
   logic         upd_valid;
   logic         converged;
   logic         sat_flag;
   logic         seq_err;

   int compared   = 0;
   int mismatched = 0;

   grad_param_update_if gif ();

   grad_param_update #(.DIM(4), .FRACT_BITS(8), .CONV_THRESH(32'sd4)) dut (
      .clk       (clk),
      .rst       (rst),
      .lr_in     (lr_in),
      .init_en   (init_en),
      .init_idx  (init_idx),
      .init_data (init_data),
      .grad      (gif),
      .param_out (param_out),
      .upd_valid (upd_valid),
      .converged (converged),
      .sat_flag  (sat_flag),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] pack4(input logic [31:0] p0, input logic [31:0] p1,
                                          input logic [31:0] p2, input logic [31:0] p3);
      return {p3, p2, p1, p0};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic doInit(input logic [1:0] i, input logic [31:0] d);
      init_en   = 1'b1;
      init_idx  = i;
      init_data = d;
      @(negedge clk);
      init_en   = 1'b0;
   endtask

   // Present one beat and return at the falling edge after it transferred.
   task automatic applyStimulus(input logic [31:0] g, input logic l);
      int w;
      w = 0;
      gif.grad_data  = g;
      gif.grad_last  = l;
      gif.grad_valid = 1'b1;
      while (!gif.grad_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      checkOutput("beat_ready", gif.grad_ready, 1);
      @(negedge clk);
      gif.grad_valid = 1'b0;
      gif.grad_last  = 1'b0;
   endtask

   task automatic sendVector(input logic [31:0] g0, input logic [31:0] g1,
                             input logic [31:0] g2, input logic [31:0] g3, input logic [3:0] lastMask);
      applyStimulus(g0, lastMask[0]);
      applyStimulus(g1, lastMask[1]);
      applyStimulus(g2, lastMask[2]);
      applyStimulus(g3, lastMask[3]);
   endtask

   // Entered at the falling edge after the last beat's transfer edge k.
   task automatic finishVector(input logic expConv);
      int n;
      n = 0;
      checkOutput("ready_drain", gif.grad_ready, 0);
      while (!upd_valid && n < 10) begin
         @(negedge clk);
         n++;
         if (!upd_valid) checkOutput("ready_drain", gif.grad_ready, 0);
      end
      init_en = 1'b0;
      checkOutput("upd_latency", n, 2);
      checkOutput("ready_done", gif.grad_ready, 0);
      checkOutput("converged", converged, expConv);
      @(negedge clk);
      checkOutput("upd_pulse_end", upd_valid, 0);
      checkOutput("ready_back", gif.grad_ready, 1);
   endtask

   initial begin
      int updSeen;
      rst            = 1'b1;
      lr_in          = '0;
      init_en        = 1'b0;
      init_idx       = '0;
      init_data      = '0;
      gif.grad_valid = 1'b0;
      gif.grad_data  = '0;
      gif.grad_last  = 1'b0;
      idle(2);
      checkOutput("rst_param", param_out, 0);
      checkOutput("rst_ready", gif.grad_ready, 1);
      checkOutput("rst_upd", upd_valid, 0);
      checkOutput("rst_conv", converged, 0);
      checkOutput("rst_sat", sat_flag, 0);
      checkOutput("rst_seq", seq_err, 0);
      rst = 1'b0;
      idle(1);

      $display("[TB] basic update");
      for (int i = 0; i < 4; i++) doInit(2'(i), 32'h400);
      checkOutput("init_all", param_out, pack4(32'h400, 32'h400, 32'h400, 32'h400));
      lr_in = 32'h80;
      sendVector(32'h200, 32'h200, 32'h200, 32'h200, 4'b1000);
      finishVector(1'b0);
      checkOutput("basic_params", param_out, pack4(32'h300, 32'h300, 32'h300, 32'h300));
      checkOutput("basic_sat", sat_flag, 0);
      checkOutput("basic_seq", seq_err, 0);

      $display("[TB] convergence");
      sendVector(32'h6, 32'h6, 32'h6, 32'h6, 4'b1000);
      finishVector(1'b1);
      checkOutput("conv_params", param_out, pack4(32'h2FD, 32'h2FD, 32'h2FD, 32'h2FD));
      sendVector(32'h6, 32'h6, 32'h8, 32'h6, 4'b1000);
      finishVector(1'b0);
      checkOutput("noconv_params", param_out, pack4(32'h2FA, 32'h2FA, 32'h2F9, 32'h2FA));

      $display("[TB] backpressure");
      for (int i = 0; i < 4; i++) doInit(2'(i), 32'h1000);
      lr_in = 32'h100;
      applyStimulus(32'h100, 1'b0);
      checkOutput("s2_pre", param_out[31:0], 32'h1000);
      idle(1);
      checkOutput("s2_post", param_out[31:0], 32'hF00);
      checkOutput("gap_ready", gif.grad_ready, 1);
      for (int b = 1; b < 4; b++) begin
         idle(int'($urandom_range(0, 3)));
         applyStimulus(32'h100 * (b + 1), b == 3);
      end
      finishVector(1'b0);
      checkOutput("bp_params", param_out, pack4(32'hF00, 32'hE00, 32'hD00, 32'hC00));

      $display("[TB] init gating");
      init_en   = 1'b1;
      init_idx  = 2'd1;
      init_data = 32'hDEAD;
      applyStimulus(32'h10, 1'b0);
      init_en = 1'b0;
      applyStimulus(32'h10, 1'b0);
      idle(1);
      init_en  = 1'b1;
      init_idx = 2'd3;
      idle(2);
      init_en = 1'b0;
      checkOutput("init_gate_mid", param_out, pack4(32'hEF0, 32'hDF0, 32'hD00, 32'hC00));
      applyStimulus(32'h10, 1'b0);
      applyStimulus(32'h10, 1'b1);
      init_en  = 1'b1;
      init_idx = 2'd0;
      finishVector(1'b0);
      checkOutput("init_gate_end", param_out, pack4(32'hEF0, 32'hDF0, 32'hCF0, 32'hBF0));

      $display("[TB] early grad_last");
      applyStimulus(32'h0, 1'b0);
      applyStimulus(32'h0, 1'b1);
      checkOutput("seq_err_early", seq_err, 1);
      checkOutput("still_accepting", gif.grad_ready, 1);
      checkOutput("no_early_upd", upd_valid, 0);
      applyStimulus(32'h0, 1'b0);
      applyStimulus(32'h0, 1'b1);
      finishVector(1'b1);
      checkOutput("seq_params", param_out, pack4(32'hEF0, 32'hDF0, 32'hCF0, 32'hBF0));

      $display("[TB] saturation");
      checkOutput("sat_before", sat_flag, 0);
      doInit(2'd0, 32'h8000_0100);
      sendVector(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 4'b1000);
      finishVector(1'b0);
      checkOutput("sat_sub_params", param_out, pack4(32'h8000_0000, 32'hDF0, 32'hCF0, 32'hBF0));
      checkOutput("sat_flag", sat_flag, 1);
      doInit(2'd0, 32'h7FFF_FFFF);
      lr_in = 32'h7FFF_FFFF;
      sendVector(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b1000);
      finishVector(1'b0);
      checkOutput("sat_prod_params", param_out, pack4(32'h0, 32'h0080_0DF0, 32'hCF0, 32'hBF0));

      $display("[TB] reset mid-vector");
      lr_in = 32'h100;
      applyStimulus(32'h10, 1'b0);
      applyStimulus(32'h10, 1'b0);
      idle(1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_param", param_out, 0);
      checkOutput("mid_rst_ready", gif.grad_ready, 1);
      checkOutput("mid_rst_upd", upd_valid, 0);
      checkOutput("mid_rst_sat", sat_flag, 0);
      checkOutput("mid_rst_seq", seq_err, 0);
      checkOutput("mid_rst_conv", converged, 0);
      idle(1);
      rst = 1'b0;
      updSeen = 0;
      repeat (6) begin
         @(negedge clk);
         if (upd_valid) updSeen++;
      end
      checkOutput("no_upd_after_rst", updSeen, 0);
      sendVector(32'h10, 32'h20, 32'h30, 32'h40, 4'b0000);
      finishVector(1'b0);
      checkOutput("post_rst_params", param_out,
                  pack4(32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFD0, 32'hFFFF_FFC0));
      checkOutput("missing_last_seq", seq_err, 1);
      checkOutput("post_rst_sat", sat_flag, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
